// File: rtl/code_lock_fsm.sv
// Keypad code checker: programmable code, failed-attempt lockout, entry timeout.
// Outputs are decoded from registered state and counters only.
module code_lock_fsm #(
  parameter int unsigned                   DIGIT_W        = 4,
  parameter int unsigned                   MAX_LEN        = 8,
  parameter logic [MAX_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 32'h39008121,
  parameter int unsigned                   DEFAULT_LEN    = 8,
  parameter int unsigned                   MAX_FAILS      = 3,
  parameter int unsigned                   LOCKOUT_CYCLES = 1024,
  parameter int unsigned                   TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               digit_i,
  input  logic                             digit_valid_i,
  input  logic                             enter_i,
  input  logic                             clear_i,
  input  logic                             relock_i,
  input  logic                             prog_i,
  output logic                             door_status_correct_o,
  output logic                             door_status_incorrect_o,
  output logic                             locked_out_o,
  output logic                             prog_active_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count_o,
  output logic [$clog2(MAX_LEN+2)-1:0]     digits_entered_o
);

  localparam int unsigned CodeW    = MAX_LEN * DIGIT_W;
  localparam int unsigned CntW     = $clog2(MAX_LEN + 2);
  localparam int unsigned FailW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned TimerMax = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax);

  typedef enum logic [2:0] {
    StIdle, StEntry, StFail, StUnlocked, StProgram, StLockout
  } state_e;

  state_e              state_q, state_d;
  logic [CodeW-1:0]    code_q, code_d;
  logic [CodeW-1:0]    shadow_q, shadow_d;
  logic [CntW-1:0]     len_q, len_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FailW-1:0]    fail_q, fail_d;
  logic                mismatch_q, mismatch_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [DIGIT_W-1:0]  exp_digit;
  logic                digit_ne;
  logic                timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= '0;
      len_q      <= CntW'(DEFAULT_LEN);
      cnt_q      <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      timer_q    <= timer_d;
    end
  end

  // Stored digit at the current entry position (digit 0 lives in the MS digit).
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (cnt_q == CntW'(i)) exp_digit = code_q[(int'(MAX_LEN)-1-i)*int'(DIGIT_W) +: DIGIT_W];
    end
  end

  assign digit_ne = (digit_i != exp_digit);
  assign timeout  = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    mismatch_d = mismatch_q;
    timer_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          state_d = StIdle;
        end else if (enter_i) begin
          state_d = StFail;
          fail_d  = fail_q + 1'b1;
        end else if (digit_valid_i) begin
          state_d    = StEntry;
          mismatch_d = digit_ne;
          cnt_d      = CntW'(1);
        end
      end
      StEntry: begin
        timer_d = timer_q + 1'b1;
        if (clear_i) begin
          state_d = StIdle;
        end else if (enter_i) begin
          if (!mismatch_q && cnt_q == len_q) begin
            state_d = StUnlocked;
            fail_d  = '0;
          end else begin
            state_d = StFail;
            fail_d  = fail_q + 1'b1;
          end
        end else if (digit_valid_i && cnt_q < CntW'(MAX_LEN)) begin
          mismatch_d = mismatch_q | digit_ne;
          cnt_d      = cnt_q + 1'b1;
          timer_d    = '0;
        end else if (digit_valid_i && cnt_q == CntW'(MAX_LEN)) begin
          // One digit too many: remember it as a guaranteed failure.
          mismatch_d = 1'b1;
          cnt_d      = CntW'(MAX_LEN + 1);
          timer_d    = '0;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StFail: begin
        state_d = (fail_q == FailW'(MAX_FAILS)) ? StLockout : StIdle;
      end
      StLockout: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TimerW'(LOCKOUT_CYCLES - 1)) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      StUnlocked: begin
        if (relock_i) begin
          state_d = StIdle;
        end else if (prog_i) begin
          state_d  = StProgram;
          shadow_d = '0;
        end
      end
      StProgram: begin
        timer_d = timer_q + 1'b1;
        if (clear_i) begin
          state_d = StUnlocked;
        end else if (enter_i) begin
          if (cnt_q != '0) begin
            code_d  = shadow_q;
            len_d   = cnt_q;
            state_d = StIdle;
          end else begin
            state_d = StUnlocked;
          end
        end else if (digit_valid_i && cnt_q < CntW'(MAX_LEN)) begin
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (cnt_q == CntW'(i)) shadow_d[(int'(MAX_LEN)-1-i)*int'(DIGIT_W) +: DIGIT_W] = digit_i;
          end
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
        end else if (timeout) begin
          state_d = StUnlocked;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      if (state_d inside {StIdle, StProgram, StLockout}) cnt_d = '0;
      if (state_d == StIdle) mismatch_d = 1'b0;
    end
  end

  assign door_status_correct_o   = (state_q == StUnlocked);
  assign door_status_incorrect_o = (state_q == StFail);
  assign locked_out_o            = (state_q == StLockout);
  assign prog_active_o           = (state_q == StProgram);
  assign fail_count_o            = fail_q;
  assign digits_entered_o        = cnt_q;

endmodule

// File: doc/code_lock_fsm.md
# code_lock_fsm

Parametrised keypad code checker for the dorm door controller. It replaces the fixed 8-digit checker with these additions: a programmable code of configurable length, failed-attempt counting with timed lockout, entry timeout, and explicit clear and relock controls. It sits between the keypad debouncer/encoder, which supplies `digit` with `digit_valid`/`enter` pulses, and the door actuator/status LEDs.

## Interface
- `DIGIT_W`, 4: width of one keypad digit.
- `MAX_LEN`, 8: maximum code length in digits.
- `DEFAULT_CODE`, 32'h39008121: reset code, `MAX_LEN*DIGIT_W` bits, first digit in MS digit.
- `DEFAULT_LEN`, 8: reset code length, 1..MAX_LEN.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout.
- `LOCKOUT_CYCLES`, 1024: lockout duration in clk cycles.
- `TIMEOUT_CYCLES`, 4096: idle cycles during entry before auto-abort.
- `clk` in 1: clock clk.
- `reset` in 1: reset reset, synchronous, active-high.
- `digit` in DIGIT_W: keypad value, sampled only when `digit_valid`=1.
- `digit_valid` in 1: one-cycle pulse, accept `digit`.
- `enter` in 1: one-cycle pulse, submit entry.
- `clear` in 1: abort current entry or programming.
- `relock` in 1: leave UNLOCKED.
- `prog` in 1: request code change (honoured only in UNLOCKED).
- `door_status_correct` out 1: high while UNLOCKED.
- `door_status_incorrect` out 1: one-cycle pulse per failed attempt.
- `locked_out` out 1: high while LOCKOUT.
- `prog_active` out 1: high while PROGRAM.
- `fail_count` out $clog2(MAX_FAILS+1): consecutive failures.
- `digits_entered` out $clog2(MAX_LEN+2): digits taken this entry, saturating at MAX_LEN+1.

## Operation
- States: IDLE, ENTRY, FAIL, UNLOCKED, PROGRAM, LOCKOUT. Outputs are Moore-decoded from registered state and counters.
- Code storage: `code_reg` (MAX_LEN*DIGIT_W) and `code_len`. Digit i is compared against bits `[(MAX_LEN-1-i)*DIGIT_W +: DIGIT_W]`.
- Reset loads `code_reg`=DEFAULT_CODE and `code_len`=DEFAULT_LEN. It clears the state to IDLE and clears `fail_count`, `digits_entered`, and all timers. All outputs are 0 after reset.
- Input priority: reset > clear > enter > digit_valid. A digit presented in the same cycle as `enter` is dropped.
- IDLE:
  - `digit_valid` compares digit 0, sets `mismatch` if unequal, sets count to 1, and moves to ENTRY.
  - `enter` with count 0 moves to FAIL.
- ENTRY:
  - Each `digit_valid` with count<MAX_LEN compares digit[count] and ORs the result into `mismatch`, then increments count.
  - A digit with count=MAX_LEN sets `mismatch` and count=MAX_LEN+1. Further digits are ignored.
  - `enter`: if `!mismatch && count==code_len`, go to UNLOCKED and clear `fail_count`. Otherwise go to FAIL.
  - `clear` goes to IDLE with no failure counted.
  - Timeout (TIMEOUT_CYCLES cycles with no `digit_valid`) goes to IDLE with no failure counted.
- FAIL: lasts one cycle and increments `fail_count`. Next state is LOCKOUT if the new count equals MAX_FAILS, else IDLE.
- LOCKOUT: all inputs except reset are ignored. After exactly LOCKOUT_CYCLES cycles it goes to IDLE and clears `fail_count`.
- UNLOCKED:
  - `relock` goes to IDLE.
  - `prog` goes to PROGRAM, clearing the shadow register and count.
  - `relock` and `prog` together: relock wins.
- PROGRAM:
  - Digits are written into the shadow at position count. Digits past MAX_LEN are ignored.
  - `enter` with count≥1 commits shadow→`code_reg` and count→`code_len`, then goes to IDLE.
  - `enter` with count 0, `clear`, or timeout returns to UNLOCKED with the code unchanged.
- `digits_entered` resets to 0 on every entry into IDLE, PROGRAM, or LOCKOUT.

## Timing
- Single clock domain, all registers on posedge `clk`.
- Entry latency: `enter` at cycle N changes the state at edge N+1. `door_status_correct` or `door_status_incorrect` is visible in cycle N+1.
- `door_status_incorrect` is high for exactly one cycle, and `fail_count` updates in that same cycle.
- Lockout path: `locked_out` rises the cycle after FAIL and stays high for LOCKOUT_CYCLES cycles.
- Back-to-back pulses: `digit_valid` may assert on every cycle. Inputs arriving during FAIL are ignored.
- Timeout counter: cleared on every accepted digit and on state entry. It fires when it reaches TIMEOUT_CYCLES-1.
- Reset mid-entry, mid-program, or mid-lockout takes effect at the next edge. The default code is restored.

## Test plan
- Default code 3,9,0,0,8,1,2,1 then `enter`: `door_status_correct`=1 the next cycle and `fail_count`=0. `relock` returns to IDLE with all outputs 0.
- Sequence 3,9,0,0,7,1,2,1 then `enter`: one-cycle `door_status_incorrect` and `fail_count`=1. A correct code afterwards unlocks and clears `fail_count` to 0.
- Three wrong entries: `locked_out`=1 for exactly 1024 cycles. The correct code entered during lockout has no effect. After lockout the state is IDLE and `fail_count`=0.
- Unlock, then `prog`, digits 1,2,3,4, then `enter`: `prog_active` falls and the state is IDLE. Entering 1,2,3,4 unlocks. Entering the old 8-digit code fails.
- Nine digits (correct 8 + extra 5) then `enter`: fail, with `digits_entered`=9.
- Timeout: 3,9 then 4096 idle cycles gives IDLE with `fail_count` unchanged. Reset after 3,9,0: IDLE, outputs 0, default code restored.
